// File: rtl/mem_access_stage.sv
// Memory-access stage: drives the data memory from the EX/MEM bundle and registers the MEM/WB bundle.
// Latency 1 for ALU ops and stores, READ_LAT+1 for loads; stall_out holds upstream while a load is in flight.
module mem_access_stage #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 13,
    parameter int READ_LAT         = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic                        flush,
    input  logic                        mem_rd_in,
    input  logic                        mem_wr_in,
    input  logic                        wb_mux_contrl_in,
    input  logic                        wb_enable_in,
    input  logic                        pc_en_in,
    input  logic [3:0]                  rd_in,
    input  logic [ARQ-1:0]              alu_result,
    input  logic [ARQ-1:0]              store_data,
    output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [ARQ-1:0]              mem_wdata,
    input  logic [ARQ-1:0]              mem_rdata,
    output logic                        stall_out,
    output logic                        addr_err,
    output logic                        valid_wb,
    output logic                        wb_mux_contrl,
    output logic                        wb_enable_wb,
    output logic                        pc_en_wb,
    output logic [3:0]                  rd_wb,
    output logic [ARQ-1:0]              alu_result_wb,
    output logic [ARQ-1:0]              mem_result_wb
);

    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_t         r_state;
    state_t         w_next;
    logic [2:0]     r_cnt;

    logic           r_h_mux;
    logic           r_h_wben;
    logic           r_h_pcen;
    logic [3:0]     r_h_rd;
    logic [ARQ-1:0] r_h_alu;

    logic           r_valid_wb;
    logic           r_wb_mux;
    logic           r_wb_en;
    logic           r_pc_en;
    logic [3:0]     r_rd_wb;
    logic [ARQ-1:0] r_alu_wb;
    logic [ARQ-1:0] r_mem_wb;

    logic w_accept;
    logic w_illegal;
    logic w_load;
    logic w_store;
    logic w_done;

    // Combinational strobes are gated by rst so every output reads 0 while reset is asserted.
    assign w_accept  = ~rst & (r_state == IDLE) & valid_in & ~flush;
    assign w_illegal = ((mem_rd_in | mem_wr_in) & (|alu_result[ARQ-1:MEMORY_ADDR_SIZE]))
                     | (mem_rd_in & mem_wr_in);
    assign w_load    = w_accept & mem_rd_in & ~w_illegal;
    assign w_store   = w_accept & mem_wr_in & ~w_illegal;
    assign w_done    = (r_state == RD_WAIT) & ~flush & (r_cnt == LAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_next = RD_WAIT;
            RD_WAIT: if (flush || (r_cnt == LAT)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = w_load;
        mem_wr_en = w_store;
        addr_err  = w_accept & w_illegal;
        stall_out = (r_state == RD_WAIT);
        mem_wdata = rst ? '0 : store_data;
        if (rst) begin
            mem_addr = '0;
        end else if (r_state == RD_WAIT) begin
            mem_addr = r_h_alu[MEMORY_ADDR_SIZE-1:0];
        end else begin
            mem_addr = alu_result[MEMORY_ADDR_SIZE-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_h_mux    <= 1'b0;
            r_h_wben   <= 1'b0;
            r_h_pcen   <= 1'b0;
            r_h_rd     <= '0;
            r_h_alu    <= '0;
            r_valid_wb <= 1'b0;
            r_wb_mux   <= 1'b0;
            r_wb_en    <= 1'b0;
            r_pc_en    <= 1'b0;
            r_rd_wb    <= '0;
            r_alu_wb   <= '0;
            r_mem_wb   <= '0;
        end else begin
            r_valid_wb <= 1'b0;
            if (w_load) begin
                r_cnt <= 3'd1;
            end else if (r_state == RD_WAIT) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_accept) begin
                r_h_mux  <= wb_mux_contrl_in;
                r_h_wben <= wb_enable_in;
                r_h_pcen <= pc_en_in;
                r_h_rd   <= rd_in;
                r_h_alu  <= alu_result;
            end
            // Everything except a legal load retires straight into MEM/WB.
            if (w_accept && !w_load) begin
                r_valid_wb <= 1'b1;
                r_wb_mux   <= wb_mux_contrl_in;
                r_wb_en    <= wb_enable_in & ~w_illegal;
                r_pc_en    <= pc_en_in;
                r_rd_wb    <= rd_in;
                r_alu_wb   <= alu_result;
            end
            if (w_done) begin
                r_valid_wb <= 1'b1;
                r_wb_mux   <= r_h_mux;
                r_wb_en    <= r_h_wben;
                r_pc_en    <= r_h_pcen;
                r_rd_wb    <= r_h_rd;
                r_alu_wb   <= r_h_alu;
                r_mem_wb   <= mem_rdata;
            end
        end
    end

    assign valid_wb      = r_valid_wb;
    assign wb_mux_contrl = r_wb_mux;
    assign wb_enable_wb  = r_wb_en;
    assign pc_en_wb      = r_pc_en;
    assign rd_wb         = r_rd_wb;
    assign alu_result_wb = r_alu_wb;
    assign mem_result_wb = r_mem_wb;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, directed multi-cycle sequences, and random traffic vs a reference model.
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, flush, mem_rd_in, mem_wr_in;
    logic        wb_mux_contrl_in, wb_enable_in, pc_en_in;
    logic [3:0]  rd_in;
    logic [15:0] alu_result, store_data;
    logic [12:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [15:0] mem_wdata, mem_rdata;
    logic        stall_out, addr_err, valid_wb;
    logic        wb_mux_contrl, wb_enable_wb, pc_en_wb;
    logic [3:0]  rd_wb;
    logic [15:0] alu_result_wb, mem_result_wb;

    mem_access_stage #(.ARQ(16), .MEMORY_ADDR_SIZE(13), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .wb_mux_contrl_in(wb_mux_contrl_in), .wb_enable_in(wb_enable_in),
        .pc_en_in(pc_en_in), .rd_in(rd_in), .alu_result(alu_result),
        .store_data(store_data), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_out(stall_out), .addr_err(addr_err), .valid_wb(valid_wb),
        .wb_mux_contrl(wb_mux_contrl), .wb_enable_wb(wb_enable_wb),
        .pc_en_wb(pc_en_wb), .rd_wb(rd_wb), .alu_result_wb(alu_result_wb),
        .mem_result_wb(mem_result_wb)
    );

    always #5 clk = ~clk;

    // Memory model: data becomes valid READ_LAT cycles after the read strobe, garbage before that.
    logic [15:0] tb_mem [0:8191];
    logic [12:0] lat_addr = '0;
    int          age = 100;
    always @(posedge clk) begin
        if (mem_rd_en) begin
            lat_addr <= mem_addr;
            age      <= 0;
        end else if (age < 100) begin
            age <= age + 1;
        end
    end
    assign mem_rdata = (age >= RL - 1) ? tb_mem[lat_addr] : 16'hDEAD;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic rd, input logic wr,
                         input logic mux, input logic wben, input logic pcen,
                         input logic [3:0] r, input logic [15:0] alu, input logic [15:0] sd);
        valid_in = v; flush = fl; mem_rd_in = rd; mem_wr_in = wr;
        wb_mux_contrl_in = mux; wb_enable_in = wben; pc_en_in = pcen;
        rd_in = r; alu_result = alu; store_data = sd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    endtask

    typedef struct {
        logic        v, fl, rd, wr, mux, wben, pcen;
        logic [3:0]  r;
        logic [15:0] alu, sd;
        logic        e_rd, e_wr, e_err, e_vwb, e_wben;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic fl, input logic rd, input logic wr,
                                input logic mux, input logic wben, input logic pcen,
                                input logic [3:0] r, input logic [15:0] alu, input logic [15:0] sd,
                                input logic e_rd, input logic e_wr, input logic e_err,
                                input logic e_vwb, input logic e_wben);
        vec_t t;
        t.v = v; t.fl = fl; t.rd = rd; t.wr = wr; t.mux = mux; t.wben = wben; t.pcen = pcen;
        t.r = r; t.alu = alu; t.sd = sd;
        t.e_rd = e_rd; t.e_wr = e_wr; t.e_err = e_err; t.e_vwb = e_vwb; t.e_wben = e_wben;
        return t;
    endfunction

    vec_t vt [9];

    // Random-phase stimulus and reference-model state
    logic        v, fl, rdb, wrb, mux, wben, pcen;
    logic [3:0]  r;
    logic [15:0] alu, sd;
    int          wait_c;
    logic        exp_vwb, acc, illegal, e_rden, e_wren;
    logic        e_mux, e_wben, e_pcen, p_mux, p_wben, p_pcen;
    logic [3:0]  e_rd, p_rd;
    logic [15:0] e_alu, e_mem, p_alu;
    logic [7:0]  b_rden, b_stall, b_vwb;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 8192; a++) tb_mem[a] = 16'((a * 40503) ^ 16'h5A5A);
        tb_mem[13'h0020] = 16'h1234;
        tb_mem[13'h0030] = 16'hCAFE;

        vt[0] = mk(1,0,0,0,0,1,0,4'h3,16'h00A5,16'h0000, 0,0,0,1,1);
        vt[1] = mk(1,0,0,1,0,0,1,4'h7,16'h0010,16'hBEEF, 0,1,0,1,0);
        vt[2] = mk(1,0,1,0,1,1,0,4'h2,16'h2000,16'h0000, 0,0,1,1,0);
        vt[3] = mk(1,0,1,1,1,1,0,4'h4,16'h0005,16'h0000, 0,0,1,1,0);
        vt[4] = mk(1,0,0,1,0,1,0,4'h1,16'h8001,16'h1111, 0,0,1,1,0);
        vt[5] = mk(1,1,1,0,1,1,0,4'h6,16'h0030,16'h0000, 0,0,0,0,0);
        vt[6] = mk(0,0,0,1,0,1,0,4'h6,16'h0044,16'h2222, 0,0,0,0,0);
        vt[7] = mk(1,0,0,0,0,1,1,4'h9,16'hFFFF,16'h0000, 0,0,0,1,1);
        vt[8] = mk(1,0,0,1,0,1,0,4'hA,16'h1FFF,16'h3333, 0,1,0,1,1);

        rst = 1'b1;
        idle_in();
        #12;
        chk("rst_valid_wb", 32'(valid_wb), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_result", 32'(mem_result_wb), 32'd0);
        chk("rst_alu_wb", 32'(alu_result_wb), 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            drive(vt[i].v, vt[i].fl, vt[i].rd, vt[i].wr, vt[i].mux, vt[i].wben, vt[i].pcen,
                  vt[i].r, vt[i].alu, vt[i].sd);
            @(negedge clk);
            chk("tbl_rd_en", 32'(mem_rd_en), 32'(vt[i].e_rd));
            chk("tbl_wr_en", 32'(mem_wr_en), 32'(vt[i].e_wr));
            chk("tbl_addr_err", 32'(addr_err), 32'(vt[i].e_err));
            chk("tbl_stall0", 32'(stall_out), 32'd0);
            if (vt[i].e_wr) begin
                chk("tbl_mem_addr", 32'(mem_addr), 32'(vt[i].alu[12:0]));
                chk("tbl_mem_wdata", 32'(mem_wdata), 32'(vt[i].sd));
            end
            @(posedge clk); #1;
            idle_in();
            @(negedge clk);
            chk("tbl_valid_wb", 32'(valid_wb), 32'(vt[i].e_vwb));
            chk("tbl_stall1", 32'(stall_out), 32'd0);
            if (vt[i].e_vwb) begin
                chk("tbl_wb_enable", 32'(wb_enable_wb), 32'(vt[i].e_wben));
                chk("tbl_alu_wb", 32'(alu_result_wb), 32'(vt[i].alu));
                chk("tbl_rd_wb", 32'(rd_wb), 32'(vt[i].r));
                chk("tbl_pc_en_wb", 32'(pc_en_wb), 32'(vt[i].pcen));
            end
        end

        // Single load, READ_LAT=2: strobe c0, stall c1-c2, result c3
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 16'h0020, 16'h0000);
        @(negedge clk);
        chk("ld_rd_en_c0", 32'(mem_rd_en), 32'd1);
        chk("ld_addr_c0", 32'(mem_addr), 32'h20);
        chk("ld_stall_c0", 32'(stall_out), 32'd0);
        @(posedge clk); #1; idle_in();
        @(negedge clk);
        chk("ld_stall_c1", 32'(stall_out), 32'd1);
        chk("ld_rd_en_c1", 32'(mem_rd_en), 32'd0);
        chk("ld_addr_held_c1", 32'(mem_addr), 32'h20);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld_stall_c2", 32'(stall_out), 32'd1);
        chk("ld_valid_c2", 32'(valid_wb), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld_stall_c3", 32'(stall_out), 32'd0);
        chk("ld_valid_c3", 32'(valid_wb), 32'd1);
        chk("ld_data_c3", 32'(mem_result_wb), 32'h1234);
        chk("ld_mux_c3", 32'(wb_mux_contrl), 32'd1);
        chk("ld_rd_wb_c3", 32'(rd_wb), 32'd5);
        chk("ld_alu_wb_c3", 32'(alu_result_wb), 32'h20);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld_valid_c4", 32'(valid_wb), 32'd0);

        // Back-to-back loads, second held under stall
        b_rden  = 8'b0000_1001;
        b_stall = 8'b0011_0110;
        b_vwb   = 8'b0100_1000;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0020, 16'h0);
            else if (c <= 3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0030, 16'h0);
            else idle_in();
            @(negedge clk);
            chk($sformatf("b2b_rd_en_c%0d", c), 32'(mem_rd_en), 32'(b_rden[c]));
            chk($sformatf("b2b_stall_c%0d", c), 32'(stall_out), 32'(b_stall[c]));
            chk($sformatf("b2b_valid_c%0d", c), 32'(valid_wb), 32'(b_vwb[c]));
            if (c == 6) begin
                chk("b2b_data_c6", 32'(mem_result_wb), 32'hCAFE);
                chk("b2b_rd_wb_c6", 32'(rd_wb), 32'd2);
            end
        end

        // Flush during RD_WAIT aborts the load
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 0) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0040, 16'h0);
            else if (c == 1) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0);
            else idle_in();
            @(negedge clk);
            if (c >= 1) chk($sformatf("fl_valid_c%0d", c), 32'(valid_wb), 32'd0);
            if (c == 1) chk("fl_stall_c1", 32'(stall_out), 32'd1);
            if (c >= 2) chk($sformatf("fl_stall_c%0d", c), 32'(stall_out), 32'd0);
        end
        chk("fl_mem_result_kept", 32'(mem_result_wb), 32'hCAFE);

        // Asynchronous reset in the middle of RD_WAIT
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 16'h0050, 16'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 16'h0123, 16'h5555);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", 32'(stall_out), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("arst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("arst_wdata", 32'(mem_wdata), 32'd0);
        chk("arst_addr_err", 32'(addr_err), 32'd0);
        chk("arst_valid", 32'(valid_wb), 32'd0);
        chk("arst_ctrl", 32'({wb_mux_contrl, wb_enable_wb, pc_en_wb, rd_wb}), 32'd0);
        chk("arst_alu_wb", 32'(alu_result_wb), 32'd0);
        chk("arst_mem_wb", 32'(mem_result_wb), 32'd0);
        idle_in();
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("arst_after_valid_c%0d", c), 32'(valid_wb), 32'd0);
            chk($sformatf("arst_after_stall_c%0d", c), 32'(stall_out), 32'd0);
        end

        // Random traffic against a countdown-based reference model (state is all-zero after reset)
        wait_c = 0; exp_vwb = 1'b0; e_mem = 16'h0;
        e_alu = '0; e_rd = '0; e_mux = 1'b0; e_wben = 1'b0; e_pcen = 1'b0;
        p_alu = '0; p_rd = '0; p_mux = 1'b0; p_wben = 1'b0; p_pcen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            int k;
            @(posedge clk); #1;
            v    = ($urandom_range(0, 9) < 8);
            fl   = ($urandom_range(0, 9) == 0);
            k    = int'($urandom_range(0, 9));
            rdb  = (k >= 3 && k < 6) || (k == 9);
            wrb  = (k >= 6);
            mux  = 1'($urandom);
            wben = 1'($urandom);
            pcen = 1'($urandom);
            r    = 4'($urandom);
            alu  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191));
            sd   = 16'($urandom);
            drive(v, fl, rdb, wrb, mux, wben, pcen, r, alu, sd);
            @(negedge clk);

            chk("rnd_valid_wb", 32'(valid_wb), 32'(exp_vwb));
            chk("rnd_stall", 32'(stall_out), 32'(wait_c > 0));
            chk("rnd_mem_result", 32'(mem_result_wb), 32'(e_mem));
            if (exp_vwb) begin
                chk("rnd_alu_wb", 32'(alu_result_wb), 32'(e_alu));
                chk("rnd_ctrl_wb", 32'({wb_mux_contrl, wb_enable_wb, pc_en_wb, rd_wb}),
                    32'({e_mux, e_wben, e_pcen, e_rd}));
            end

            acc     = (wait_c == 0) && v && !fl;
            illegal = ((rdb || wrb) && (alu >= 16'd8192)) || (rdb && wrb);
            e_rden  = acc && rdb && !illegal;
            e_wren  = acc && wrb && !illegal;
            chk("rnd_rd_en", 32'(mem_rd_en), 32'(e_rden));
            chk("rnd_wr_en", 32'(mem_wr_en), 32'(e_wren));
            chk("rnd_addr_err", 32'(addr_err), 32'(acc && illegal));
            if (e_rden || e_wren) chk("rnd_mem_addr", 32'(mem_addr), 32'(alu % 16'd8192));
            if (wait_c > 0) chk("rnd_mem_addr_held", 32'(mem_addr), 32'(p_alu % 16'd8192));

            exp_vwb = 1'b0;
            if (wait_c > 0) begin
                if (fl) begin
                    wait_c = 0;
                end else begin
                    wait_c--;
                    if (wait_c == 0) begin
                        exp_vwb = 1'b1;
                        e_alu = p_alu; e_rd = p_rd; e_mux = p_mux; e_wben = p_wben; e_pcen = p_pcen;
                        e_mem = tb_mem[p_alu % 16'd8192];
                    end
                end
            end else if (acc) begin
                if (e_rden) begin
                    wait_c = RL;
                    p_alu = alu; p_rd = r; p_mux = mux; p_wben = wben; p_pcen = pcen;
                end else begin
                    exp_vwb = 1'b1;
                    e_alu = alu; e_rd = r; e_mux = mux; e_wben = wben && !illegal; e_pcen = pcen;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage of the 16-bit RSA ASIP datapath. It sits between the EX/MEM register and write-back.
- Takes the EX-stage ALU result, store data and control bits, and drives the 13-bit-addressed data memory, which has a parameterised read latency.
- Stalls upstream while a load is outstanding, then presents a registered MEM/WB bundle to the write-back mux.

Parameters:
- ARQ, 16, datapath width.
- MEMORY_ADDR_SIZE, 13, data-memory address width.
- READ_LAT, 2, data-memory read latency in cycles (legal range 1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- valid_in  in  1  EX/MEM slot holds an instruction.
- flush  in  1  kill the in-flight or presented instruction.
- mem_rd_in  in  1  instruction is a load.
- mem_wr_in  in  1  instruction is a store.
- wb_mux_contrl_in  in  1  WB select (0 = ALU, 1 = memory).
- wb_enable_in  in  1  register-file write enable.
- pc_en_in  in  1  PC-update flag, passed through.
- rd_in  in  4  destination register.
- alu_result  in  ARQ  ALU result / effective address.
- store_data  in  ARQ  store operand.
- mem_addr  out  MEMORY_ADDR_SIZE  memory address.
- mem_rd_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  ARQ  memory write data.
- mem_rdata  in  ARQ  memory read data.
- stall_out  out  1  upstream must hold its inputs.
- addr_err  out  1  one-cycle pulse: illegal access.
- valid_wb  out  1  MEM/WB bundle valid.
- wb_mux_contrl, wb_enable_wb, pc_en_wb  out  1 each  registered control bits.
- rd_wb  out  4  registered destination register.
- alu_result_wb  out  ARQ  registered ALU result.
- mem_result_wb  out  ARQ  registered load data.

Behaviour:
- Reset:
  - One clock, asynchronous active-high reset.
  - All outputs and registers reset to 0; FSM enters IDLE.
  - Reset during RD_WAIT abandons the load; no valid_wb is produced.
- FSM states: IDLE, RD_WAIT. Instructions are accepted only in IDLE.
  - Accept condition: IDLE and valid_in and not flush.
  - On accept, control bits, rd_in and alu_result are captured into holding registers.
- Memory address:
  - mem_addr = alu_result[MEMORY_ADDR_SIZE-1:0]. It is combinational in IDLE and held from the holding register in RD_WAIT.
  - mem_wdata = store_data.
- Illegal access: either of these in an accepted instruction is illegal.
  - Load or store with alu_result[ARQ-1:MEMORY_ADDR_SIZE] != 0.
  - mem_rd_in and mem_wr_in both set.
  - Response: no memory strobe, addr_err pulses, and next cycle valid_wb=1 with wb_enable_wb forced 0.
- Non-memory op: MEM/WB registers load on the accept edge, so valid_wb=1 in the next cycle. Latency 1, no stall.
- Store:
  - mem_wr_en=1 combinationally in the accept cycle only.
  - valid_wb=1 next cycle with wb_enable_wb as supplied. Latency 1, no stall.
- Load:
  - Accept cycle k: mem_rd_en=1 for that cycle only.
  - Next state RD_WAIT, with a cycle counter set to 1.
  - stall_out=1 for cycles k+1 through k+READ_LAT.
  - Counter increments each cycle in RD_WAIT.
  - When the counter equals READ_LAT, mem_rdata is captured into mem_result_wb, held controls are copied out, and the FSM returns to IDLE.
  - valid_wb=1 in cycle k+READ_LAT+1; the next instruction can be accepted in that same cycle.
  - Load throughput is one per READ_LAT+1 cycles.
- valid_wb: high for exactly one cycle per completed instruction, otherwise 0. MEM/WB data registers hold their last values when valid_wb=0.
- stall_out: equals (state==RD_WAIT). It is 0 in IDLE regardless of inputs.
- Flush:
  - In IDLE: the presented instruction is dropped. No strobes, no valid_wb, no addr_err.
  - In RD_WAIT: the load is aborted, the FSM returns to IDLE next cycle, valid_wb stays 0, and any late mem_rdata is ignored.
- pc_en_wb: passed through unmodified.

Test Plan (READ_LAT=2):
- ALU op: valid_in=1, alu_result=16'h00A5, wb_enable_in=1, rd_in=3.
  - Next cycle: valid_wb=1, alu_result_wb=16'h00A5, rd_wb=3, wb_enable_wb=1, stall_out never high.
- Store: alu_result=16'h0010, store_data=16'hBEEF.
  - Same cycle: mem_wr_en=1, mem_addr=13'h0010, mem_wdata=16'hBEEF.
  - Next cycle: valid_wb=1.
- Load at cycle 0: alu_result=16'h0020, memory returns 16'h1234.
  - mem_rd_en=1 in cycle 0.
  - stall_out=1 in cycles 1–2.
  - valid_wb=1 in cycle 3, mem_result_wb=16'h1234, wb_mux_contrl=1.
- Back-to-back loads, the second held under stall:
  - Second mem_rd_en in cycle 3.
  - valid_wb pulses in cycles 3 and 6.
- Out-of-range load, alu_result=16'h2000:
  - No mem_rd_en; addr_err pulses in cycle 0.
  - valid_wb=1 with wb_enable_wb=0 in cycle 1, no stall.
- Flush and reset:
  - Load at cycle 0 with flush in cycle 1: IDLE in cycle 2, no valid_wb.
  - rst pulse mid-RD_WAIT: all outputs read 0 immediately, before the next clock edge.
